// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_pkg
// Description : Shared types and constants for the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Requester identifiers
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    // Default geometry
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 64;

endpackage : dmem_arbiter_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin pick. A lone requester wins outright; on
//               a collision the pointer decides. The pointer moves to the
//               non-winner whenever a grant is committed.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_commit,   // grant is being taken this cycle
    output logic o_valid,
    output logic o_winner
);

    logic r_ptr;
    logic w_winner;

    // Pick the winner: single requester outright, pointer on collision
    always_comb begin
        w_winner = REQ_A;
        if (i_req_a && i_req_b) begin
            w_winner = r_ptr;
        end else if (i_req_b) begin
            w_winner = REQ_B;
        end
    end

    assign o_valid  = i_req_a | i_req_b;
    assign o_winner = w_winner;

    // Hand priority to the other side after every committed grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= REQ_A;
        end else if (i_commit && o_valid) begin
            r_ptr <= ~w_winner;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Arbitrates a core (A) and a loader (B) onto one single-port
//               data memory. Three-cycle transaction: IDLE (grant/latch),
//               ACCESS (memory driven), RESP (ack, registered rdata).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_ack,
    output logic              b_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              mem_write_enable,
    output logic              mem_mode,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    // One extra bit so DEPTH == 2**ADDR_W is still representable
    localparam logic [ADDR_W:0] c_DEPTH = DEPTH[ADDR_W:0];

    state_t              r_state;
    state_t              w_next;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_id;
    logic [DATA_W-1:0]   r_rdata;
    logic                w_valid;
    logic                w_winner;
    logic                w_grant;
    logic                w_in_range;

    assign w_grant    = (r_state == ST_IDLE) && w_valid;
    assign w_in_range = ({1'b0, r_addr} < c_DEPTH);

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst      (reset),
        .i_req_a  (a_req),
        .i_req_b  (b_req),
        .i_commit (w_grant),
        .o_valid  (w_valid),
        .o_winner (w_winner)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and memory/handshake outputs
    always_comb begin
        w_next           = r_state;
        mem_mode         = 1'b1;
        mem_write_enable = 1'b0;
        a_ack            = 1'b0;
        b_ack            = 1'b0;
        err              = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_next           = ST_RESP;
                // Reset in this cycle aborts the access before the memory
                // can commit a write on the same edge.
                mem_mode         = reset;
                mem_write_enable = r_we & w_in_range & ~reset;
            end
            ST_RESP: begin
                w_next = ST_IDLE;
                a_ack  = (r_id == REQ_A);
                b_ack  = (r_id == REQ_B);
                err    = ~w_in_range;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Latch the winner's request on grant; capture the result leaving ACCESS
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_id    <= REQ_A;
            r_rdata <= '0;
        end else begin
            if (w_grant) begin
                r_id    <= w_winner;
                r_we    <= (w_winner == REQ_B) ? b_we    : a_we;
                r_addr  <= (w_winner == REQ_B) ? b_addr  : a_addr;
                r_wdata <= (w_winner == REQ_B) ? b_wdata : a_wdata;
            end
            if (r_state == ST_ACCESS) begin
                if (!w_in_range) begin
                    r_rdata <= '0;
                end else if (r_we) begin
                    r_rdata <= r_wdata;
                end else begin
                    r_rdata <= mem_data_out;
                end
            end
        end
    end

    assign rdata       = r_rdata;
    assign mem_address = r_addr;
    assign mem_data_in = r_wdata;

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter with a small
//               behavioural memory (combinational read, clocked write).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [7:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_ack, b_ack, err;
    logic [31:0] rdata;
    logic        mem_write_enable, mem_mode;
    logic [7:0]  mem_address;
    logic [31:0] mem_data_in, mem_data_out;

    int errors = 0;
    int checks = 0;

    // Behavioural memory: preload on first edge, then write when enabled.
    // Write address is truncated so a missing range gate would corrupt mem[].
    logic [31:0] mem [0:63];
    bit          loaded = 1'b0;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h100 + i;
            mem[0] <= 32'd4;
            mem[4] <= 32'd3;
            loaded <= 1'b1;
        end else if (mem_write_enable && !mem_mode) begin
            mem[mem_address[5:0]] <= mem_data_in;
        end
    end

    assign mem_data_out = mem[mem_address[5:0]];

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .a_req            (a_req),
        .a_we             (a_we),
        .a_addr           (a_addr),
        .a_wdata          (a_wdata),
        .b_req            (b_req),
        .b_we             (b_we),
        .b_addr           (b_addr),
        .b_wdata          (b_wdata),
        .a_ack            (a_ack),
        .b_ack            (b_ack),
        .rdata            (rdata),
        .err              (err),
        .mem_write_enable (mem_write_enable),
        .mem_mode         (mem_mode),
        .mem_address      (mem_address),
        .mem_data_in      (mem_data_in),
        .mem_data_out     (mem_data_out)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        tick; tick; tick;
        reset = 1'b0;
        tick;
        checks += 6;
        if (a_ack !== 1'b0) begin errors++; $display("FAIL rst_a_ack got=%b exp=0", a_ack); end
        if (b_ack !== 1'b0) begin errors++; $display("FAIL rst_b_ack got=%b exp=0", b_ack); end
        if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err); end
        if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
        if (mem_mode !== 1'b1) begin errors++; $display("FAIL rst_mode got=%b exp=1", mem_mode); end
        if (mem_write_enable !== 1'b0) begin errors++; $display("FAIL rst_we got=%b exp=0", mem_write_enable); end
    endtask

    task automatic test_a_write_read;
        a_req = 1; a_we = 1; a_addr = 8'd8; a_wdata = 32'hDEAD;
        tick;   // ACCESS
        checks += 4;
        if (a_ack !== 1'b0) begin errors++; $display("FAIL wr_early_ack got=%b exp=0", a_ack); end
        if (mem_write_enable !== 1'b1) begin errors++; $display("FAIL wr_we got=%b exp=1", mem_write_enable); end
        if (mem_mode !== 1'b0) begin errors++; $display("FAIL wr_mode got=%b exp=0", mem_mode); end
        if (mem_address !== 8'd8) begin errors++; $display("FAIL wr_addr got=%0d exp=8", mem_address); end
        tick;   // RESP
        checks += 4;
        if (a_ack !== 1'b1) begin errors++; $display("FAIL wr_ack got=%b exp=1", a_ack); end
        if (b_ack !== 1'b0) begin errors++; $display("FAIL wr_b_ack got=%b exp=0", b_ack); end
        if (err !== 1'b0) begin errors++; $display("FAIL wr_err got=%b exp=0", err); end
        if (mem_write_enable !== 1'b0) begin errors++; $display("FAIL wr_resp_we got=%b exp=0", mem_write_enable); end
        a_req = 0; a_we = 0;
        tick;   // IDLE
        checks += 2;
        if (mem[8] !== 32'hDEAD) begin errors++; $display("FAIL wr_mem got=%h exp=0000dead", mem[8]); end
        if (mem_mode !== 1'b1) begin errors++; $display("FAIL wr_idle_mode got=%b exp=1", mem_mode); end
        a_req = 1; a_we = 0; a_addr = 8'd8; a_wdata = 32'h0;
        tick; tick;
        checks += 2;
        if (a_ack !== 1'b1) begin errors++; $display("FAIL rd_ack got=%b exp=1", a_ack); end
        if (rdata !== 32'hDEAD) begin errors++; $display("FAIL rd_data got=%h exp=0000dead", rdata); end
        a_req = 0;
        tick;
    endtask

    task automatic test_collision;
        reset = 1'b1; tick; reset = 1'b0;
        a_req = 1; a_we = 0; a_addr = 8'd0;
        b_req = 1; b_we = 0; b_addr = 8'd4;
        tick;
        checks += 1;
        if ({a_ack, b_ack} !== 2'b00) begin errors++; $display("FAIL col_access_acks got=%b exp=00", {a_ack, b_ack}); end
        tick;
        checks += 3;
        if (a_ack !== 1'b1) begin errors++; $display("FAIL col_a_ack got=%b exp=1", a_ack); end
        if (b_ack !== 1'b0) begin errors++; $display("FAIL col_b_early got=%b exp=0", b_ack); end
        if (rdata !== 32'd4) begin errors++; $display("FAIL col_a_rdata got=%h exp=4", rdata); end
        a_req = 0;
        tick; tick; tick;
        checks += 3;
        if (b_ack !== 1'b1) begin errors++; $display("FAIL col_b_ack got=%b exp=1", b_ack); end
        if (a_ack !== 1'b0) begin errors++; $display("FAIL col_a_again got=%b exp=0", a_ack); end
        if (rdata !== 32'd3) begin errors++; $display("FAIL col_b_rdata got=%h exp=3", rdata); end
        b_req = 0;
        tick;
    endtask

    task automatic test_back_to_back;
        logic exp_a, exp_b;
        a_req = 1; a_we = 0; a_addr = 8'd1;
        b_req = 1; b_we = 0; b_addr = 8'd2;
        for (int i = 1; i <= 11; i++) begin
            tick;
            exp_a = (i == 2) || (i == 8);
            exp_b = (i == 5) || (i == 11);
            checks += 2;
            if (a_ack !== exp_a) begin errors++; $display("FAIL b2b_a_ack cyc=%0d got=%b exp=%b", i, a_ack, exp_a); end
            if (b_ack !== exp_b) begin errors++; $display("FAIL b2b_b_ack cyc=%0d got=%b exp=%b", i, b_ack, exp_b); end
        end
        checks += 1;
        if (rdata !== 32'h102) begin errors++; $display("FAIL b2b_rdata got=%h exp=102", rdata); end
        a_req = 0; b_req = 0;
        tick;
    endtask

    task automatic test_out_of_range;
        b_req = 1; b_we = 1; b_addr = 8'd64; b_wdata = 32'h1;
        tick;
        checks += 2;
        if (mem_write_enable !== 1'b0) begin errors++; $display("FAIL oor_we got=%b exp=0", mem_write_enable); end
        if (mem_mode !== 1'b0) begin errors++; $display("FAIL oor_mode got=%b exp=0", mem_mode); end
        tick;
        checks += 4;
        if (b_ack !== 1'b1) begin errors++; $display("FAIL oor_ack got=%b exp=1", b_ack); end
        if (err !== 1'b1) begin errors++; $display("FAIL oor_err got=%b exp=1", err); end
        if (rdata !== 32'h0) begin errors++; $display("FAIL oor_rdata got=%h exp=0", rdata); end
        if (mem_write_enable !== 1'b0) begin errors++; $display("FAIL oor_resp_we got=%b exp=0", mem_write_enable); end
        b_req = 0; b_we = 0;
        tick;
        checks += 2;
        if (err !== 1'b0) begin errors++; $display("FAIL oor_err_clear got=%b exp=0", err); end
        if (mem[0] !== 32'd4) begin errors++; $display("FAIL oor_alias got=%h exp=4", mem[0]); end
    endtask

    task automatic test_reset_abort;
        a_req = 1; a_we = 1; a_addr = 8'd9; a_wdata = 32'h1234;
        tick;   // ACCESS
        reset = 1'b1;
        a_req = 0; a_we = 0;
        tick;
        reset = 1'b0;
        checks += 5;
        if (a_ack !== 1'b0) begin errors++; $display("FAIL abort_ack got=%b exp=0", a_ack); end
        if (mem_mode !== 1'b1) begin errors++; $display("FAIL abort_mode got=%b exp=1", mem_mode); end
        if (mem_write_enable !== 1'b0) begin errors++; $display("FAIL abort_we got=%b exp=0", mem_write_enable); end
        if (mem_address !== 8'd0) begin errors++; $display("FAIL abort_addr got=%0d exp=0", mem_address); end
        if (mem[9] !== 32'h109) begin errors++; $display("FAIL abort_mem got=%h exp=109", mem[9]); end
        tick;
        checks += 1;
        if (a_ack !== 1'b0) begin errors++; $display("FAIL abort_late_ack got=%b exp=0", a_ack); end
        // Pointer had moved to B at the aborted grant; reset returns it to A
        a_req = 1; a_we = 0; a_addr = 8'd2;
        b_req = 1; b_we = 0; b_addr = 8'd5;
        tick; tick;
        checks += 2;
        if (a_ack !== 1'b1) begin errors++; $display("FAIL abort_ptr_a got=%b exp=1", a_ack); end
        if (rdata !== 32'h102) begin errors++; $display("FAIL abort_ptr_rdata got=%h exp=102", rdata); end
        a_req = 0;
        tick; tick; tick;
        checks += 2;
        if (b_ack !== 1'b1) begin errors++; $display("FAIL abort_b_ack got=%b exp=1", b_ack); end
        if (rdata !== 32'h105) begin errors++; $display("FAIL abort_b_rdata got=%h exp=105", rdata); end
        b_req = 0;
        tick;
    endtask

    task automatic test_held_request;
        a_req = 1; a_we = 0; a_addr = 8'd3;
        tick;   // A in ACCESS
        b_req = 1; b_we = 0; b_addr = 8'd6;
        tick;   // RESP for A
        checks += 2;
        if (a_ack !== 1'b1) begin errors++; $display("FAIL held_a_ack got=%b exp=1", a_ack); end
        if (rdata !== 32'h103) begin errors++; $display("FAIL held_a_rdata got=%h exp=103", rdata); end
        a_req = 0;
        tick;   // IDLE, B arbitrated
        checks += 1;
        if (b_ack !== 1'b0) begin errors++; $display("FAIL held_b_early got=%b exp=0", b_ack); end
        tick;   // ACCESS for B
        checks += 1;
        if (mem_address !== 8'd6) begin errors++; $display("FAIL held_b_addr got=%0d exp=6", mem_address); end
        tick;   // RESP for B
        checks += 2;
        if (b_ack !== 1'b1) begin errors++; $display("FAIL held_b_ack got=%b exp=1", b_ack); end
        if (rdata !== 32'h106) begin errors++; $display("FAIL held_b_rdata got=%h exp=106", rdata); end
        b_req = 0;
        tick;
    endtask

    initial begin
        test_reset;
        test_a_write_read;
        test_collision;
        test_back_to_back;
        test_out_of_range;
        test_reset_abort;
        test_held_request;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
